llander_thrust_ctrl: RTL and testbench

- Sequences the thrust-lever value fed to the Lunar Lander core.
- Selects between the analog-stick and D-pad thrust sources.
- Ramps the D-pad accumulator at a fixed tick rate, clamps to the board's 0..254 DAC range, and slews glitch-free when the source changes.
- Also generates a fixed-width, one-per-press active-low coin pulse.
- Sits between the hps_io joystick/status wiring and LLANDER_TOP's THRUST and COIN inputs, in the clk_25 domain.

---
 rtl/llander_thrust_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_llander_thrust_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llander_thrust_ctrl.sv
// Thrust-lever sequencer for the Lunar Lander core: analog/D-pad source select,
// tick-rate D-pad ramp, glitch-free slew on source change, and a one-shot coin pulse.
module llander_thrust_ctrl #(
    parameter int TICK_DIV   = 98425,
    parameter int THRUST_MAX = 254,
    parameter int SLEW_STEP  = 8,
    parameter int COIN_PULSE = 250000
) (
    input  logic       clk_25,
    input  logic       RESET_L,
    input  logic       mode_dpad,
    input  logic [7:0] analog_y,
    input  logic       dpad_up,
    input  logic       dpad_down,
    input  logic       coin_btn,
    output logic [7:0] thrust,
    output logic       thrust_src,
    output logic       slewing,
    output logic       coin_l,
    output logic [1:0] thrust_state,
    output logic [1:0] coin_state
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (COIN_PULSE > 1) ? $clog2(COIN_PULSE) : 1;
    localparam logic [7:0] TMAX = 8'(THRUST_MAX);
    localparam logic [7:0] STEP = 8'(SLEW_STEP);

    typedef enum logic [1:0] {
        SLEW         = 2'd0,
        TRACK_ANALOG = 2'd1,
        TRACK_DPAD   = 2'd2
    } thr_state_t;

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_PULSE = 2'd1,
        C_WAIT  = 2'd2
    } coin_state_t;

    // Reset asserts asynchronously and releases on the second clock edge.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Stick Y is inverted so full forward (-128) gives full thrust.
    logic [8:0] a_v;
    logic [7:0] a_tgt;

    assign a_v = 9'd127 - {analog_y[7], analog_y};

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            a_tgt <= 8'd0;
        end else if (a_v > {1'b0, TMAX}) begin
            a_tgt <= TMAX;
        end else begin
            a_tgt <= a_v[7:0];
        end
    end

    logic [7:0] dpad_acc;

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            dpad_acc <= 8'd0;
        end else if (tick && mode_dpad) begin
            if (dpad_up && !dpad_down && dpad_acc < TMAX) begin
                dpad_acc <= dpad_acc + 8'd1;
            end else if (dpad_down && !dpad_up && dpad_acc != 8'd0) begin
                dpad_acc <= dpad_acc - 8'd1;
            end
        end
    end

    logic [7:0] target;
    logic [7:0] slew_val;

    assign target = mode_dpad ? dpad_acc : a_tgt;

    always_comb begin
        slew_val = thrust;
        if (target > thrust) begin
            slew_val = ((target - thrust) > STEP) ? (thrust + STEP) : target;
        end else if (target < thrust) begin
            slew_val = ((thrust - target) > STEP) ? (thrust - STEP) : target;
        end
    end

    thr_state_t thr_q, thr_next;
    logic [7:0] thrust_next;
    logic       last_src;

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            thr_q    <= SLEW;
            thrust   <= 8'd0;
            last_src <= 1'b0;
        end else begin
            thr_q    <= thr_next;
            thrust   <= thrust_next;
            last_src <= thrust_src;
        end
    end

    // In SLEW the reported source stays at the last settled one.
    always_comb begin
        thr_next    = thr_q;
        thrust_next = thrust;
        slewing     = 1'b0;
        thrust_src  = last_src;
        case (thr_q)
            TRACK_ANALOG: begin
                thrust_next = a_tgt;
                thrust_src  = 1'b0;
                if (mode_dpad) begin
                    thr_next = SLEW;
                end
            end
            TRACK_DPAD: begin
                thrust_next = dpad_acc;
                thrust_src  = 1'b1;
                if (!mode_dpad) begin
                    thr_next = SLEW;
                end
            end
            default: begin
                slewing = 1'b1;
                if (thrust == target) begin
                    thr_next = mode_dpad ? TRACK_DPAD : TRACK_ANALOG;
                end else if (tick) begin
                    thrust_next = slew_val;
                end
            end
        endcase
    end

    assign thrust_state = thr_q;

    logic [1:0] btn_sync;
    logic       btn;

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync <= 2'b00;
        end else begin
            btn_sync <= {btn_sync[0], coin_btn};
        end
    end

    assign btn = btn_sync[1];

    coin_state_t   coin_q, coin_next;
    logic [CW-1:0] coin_cnt, cnt_next;

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            coin_q   <= C_IDLE;
            coin_cnt <= '0;
        end else begin
            coin_q   <= coin_next;
            coin_cnt <= cnt_next;
        end
    end

    // Pulse width is fixed by the counter; C_WAIT blocks re-trigger until release.
    always_comb begin
        coin_next = coin_q;
        cnt_next  = coin_cnt;
        coin_l    = 1'b1;
        case (coin_q)
            C_IDLE: begin
                if (btn) begin
                    coin_next = C_PULSE;
                    cnt_next  = CW'(COIN_PULSE - 1);
                end
            end
            C_PULSE: begin
                coin_l = 1'b0;
                if (coin_cnt == '0) begin
                    coin_next = C_WAIT;
                end else begin
                    cnt_next = coin_cnt - CW'(1);
                end
            end
            C_WAIT: begin
                if (!btn) begin
                    coin_next = C_IDLE;
                end
            end
            default: begin
                coin_next = C_IDLE;
            end
        endcase
    end

    assign coin_state = coin_q;

endmodule

// File: tb/tb_llander_thrust_ctrl.sv
// Bench for llander_thrust_ctrl: directed scenarios plus random stimulus, every
// cycle compared against an arithmetic reference model of the thrust/coin rules.
`timescale 1ns/1ps
module tb_llander_thrust_ctrl;
    localparam int TICK_DIV   = 4;
    localparam int THRUST_MAX = 254;
    localparam int SLEW_STEP  = 8;
    localparam int COIN_PULSE = 5;

    logic       clk_25 = 1'b0;
    logic       RESET_L;
    logic       mode_dpad;
    logic [7:0] analog_y;
    logic       dpad_up;
    logic       dpad_down;
    logic       coin_btn;
    logic [7:0] thrust;
    logic       thrust_src;
    logic       slewing;
    logic       coin_l;
    logic [1:0] thrust_state;
    logic [1:0] coin_state;

    llander_thrust_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .THRUST_MAX(THRUST_MAX),
        .SLEW_STEP (SLEW_STEP),
        .COIN_PULSE(COIN_PULSE)
    ) dut (
        .clk_25      (clk_25),
        .RESET_L     (RESET_L),
        .mode_dpad   (mode_dpad),
        .analog_y    (analog_y),
        .dpad_up     (dpad_up),
        .dpad_down   (dpad_down),
        .coin_btn    (coin_btn),
        .thrust      (thrust),
        .thrust_src  (thrust_src),
        .slewing     (slewing),
        .coin_l      (coin_l),
        .thrust_state(thrust_state),
        .coin_state  (coin_state)
    );

    always #5 clk_25 = ~clk_25;

    // ---------------- reference model ----------------
    int m_hold = 0, m_tcnt = 0, m_atg = 0, m_acc = 0, m_thrust = 0;
    int m_settled = 0, m_src = 0, m_s1 = 0, m_s2 = 0, m_left = 0, m_wait = 0;

    task automatic model_reset();
        m_hold = 0; m_tcnt = 0; m_atg = 0; m_acc = 0; m_thrust = 0;
        m_settled = 0; m_src = 0; m_s1 = 0; m_s2 = 0; m_left = 0; m_wait = 0;
    endtask

    function automatic int analog_map(input logic [7:0] ay);
        int v;
        v = 127 - int'($signed(ay));
        if (v > THRUST_MAX) v = THRUST_MAX;
        return v;
    endfunction

    task automatic model_step();
        int tick_now, tgt, d;
        if (m_hold < 2) begin
            m_hold++;
        end else begin
            tick_now = (m_tcnt == TICK_DIV - 1) ? 1 : 0;
            tgt = mode_dpad ? m_acc : m_atg;
            if (m_settled != 0) begin
                m_thrust = (m_src != 0) ? m_acc : m_atg;
                if (int'(mode_dpad) != m_src) m_settled = 0;
            end else if (m_thrust == tgt) begin
                m_settled = 1;
                m_src = int'(mode_dpad);
            end else if (tick_now != 0) begin
                d = tgt - m_thrust;
                if (d > SLEW_STEP) d = SLEW_STEP;
                if (d < -SLEW_STEP) d = -SLEW_STEP;
                m_thrust = m_thrust + d;
            end
            if (tick_now != 0 && mode_dpad) begin
                if (dpad_up && !dpad_down && m_acc < THRUST_MAX) m_acc++;
                else if (dpad_down && !dpad_up && m_acc > 0) m_acc--;
            end
            m_atg = analog_map(analog_y);
            m_tcnt = (m_tcnt + 1) % TICK_DIV;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_wait = 1;
            end else if (m_wait != 0) begin
                if (m_s2 == 0) m_wait = 0;
            end else if (m_s2 != 0) begin
                m_left = COIN_PULSE;
            end
            m_s2 = m_s1;
            m_s1 = int'(coin_btn);
        end
    endtask

    always @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) model_reset();
        else model_step();
    end

    // ---------------- checking ----------------
    int   n_checks = 0;
    int   n_pass = 0;
    int   pulses = 0;
    logic prev_coin = 1'b1;
    logic prev_slew = 1'b0;
    int   prev_thr = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic cyc(input int n);
        int diff;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_25);
            check("thrust", int'(thrust), m_thrust);
            check("thrust_src", int'(thrust_src), m_src);
            check("slewing", int'(slewing), 1 - m_settled);
            check("coin_l", int'(coin_l), (m_left == 0) ? 1 : 0);
            check("thrust_max", int'(thrust <= 8'(THRUST_MAX)), 1);
            if (slewing && prev_slew) begin
                diff = int'(thrust) - prev_thr;
                if (diff < 0) diff = -diff;
                check("slew_step", int'(diff <= SLEW_STEP), 1);
            end
            if (prev_coin && !coin_l) pulses++;
            prev_coin = coin_l;
            prev_slew = slewing;
            prev_thr  = int'(thrust);
        end
    endtask

    task automatic wait_settled(input string tag, input int budget);
        int n;
        n = 0;
        cyc(1);
        while (slewing && n < budget) begin
            cyc(1);
            n++;
        end
        check(tag, int'(slewing), 0);
    endtask

    task automatic collect_slew(input int budget);
        int n, last;
        n = 0;
        last = int'(thrust);
        got_q.delete();
        while (slewing && n < budget) begin
            cyc(1);
            n++;
            if (int'(thrust) != last) begin
                got_q.push_back(thrust);
                last = int'(thrust);
            end
        end
        check("collect_done", int'(slewing), 0);
    endtask

    task automatic compare_seq(input string tag);
        int len;
        check({tag, "_len"}, got_q.size(), exp_q.size());
        len = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < len; i++) check(tag, int'(got_q[i]), int'(exp_q[i]));
    endtask

    task automatic analog_step(input logic [7:0] ay, input int exp, input int prev);
        analog_y = ay;
        cyc(1);
        check("a_lat1", int'(thrust), prev);
        cyc(1);
        check("a_lat2", int'(thrust), exp);
        check("a_src", int'(thrust_src), 0);
        check("a_slew", int'(slewing), 0);
    endtask

    task automatic coin_press(input string tag, input int hold);
        int p0;
        p0 = pulses;
        coin_btn = 1'b1;
        cyc(1); check({tag, "_pre1"}, int'(coin_l), 1);
        cyc(1); check({tag, "_pre2"}, int'(coin_l), 1);
        for (int k = 0; k < COIN_PULSE; k++) begin
            cyc(1); check({tag, "_low"}, int'(coin_l), 0);
        end
        cyc(1); check({tag, "_end"}, int'(coin_l), 1);
        cyc(hold - 3 - COIN_PULSE);
        check({tag, "_held_count"}, pulses - p0, 1);
        coin_btn = 1'b0;
        cyc(10);
        check({tag, "_rel_count"}, pulses - p0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, n, p0;
        logic [7:0] ay;
        RESET_L = 1'b1; mode_dpad = 1'b0; analog_y = 8'h00;
        dpad_up = 1'b0; dpad_down = 1'b0; coin_btn = 1'b0;
        #1 RESET_L = 1'b0;
        @(negedge clk_25);
        check("rst_thrust", int'(thrust), 0);
        check("rst_src", int'(thrust_src), 0);
        check("rst_slewing", int'(slewing), 1);
        check("rst_coin", int'(coin_l), 1);
        cyc(2);
        RESET_L = 1'b1;
        cyc(3);

        // analog mapping and 2-cycle latency
        wait_settled("settle_init", 200);
        check("a_init", int'(thrust), 127);
        analog_step(8'h80, 254, 127);
        analog_step(8'h00, 127, 254);
        analog_step(8'h7F, 0, 127);
        for (int i = 0; i < 8; i++) begin
            ay = 8'($urandom_range(255));
            analog_step(ay, analog_map(ay), int'(thrust));
        end
        analog_step(8'h7F, 0, int'(thrust));

        // D-pad ramp, clamp, hold and floor
        mode_dpad = 1'b1;
        dpad_up = 1'b1;
        cyc(20);
        t0 = int'(thrust);
        cyc(40);
        check("ramp_rate", int'(thrust) - t0, 10);
        cyc(1140);
        check("ramp_top", int'(thrust), 254);
        check("ramp_src", int'(thrust_src), 1);
        dpad_down = 1'b1;
        cyc(40);
        check("both_hold", int'(thrust), 254);
        dpad_up = 1'b0;
        cyc(1200);
        check("ramp_bottom", int'(thrust), 0);
        dpad_down = 1'b0;

        // build dpad_acc = 100, then return to analog at thrust 0
        dpad_up = 1'b1;
        cyc(400);
        dpad_up = 1'b0;
        cyc(2);
        check("acc_100", int'(thrust), 100);
        mode_dpad = 1'b0;
        wait_settled("settle_analog", 300);
        check("back_analog", int'(thrust), 0);

        // source switch slew 0 -> 100
        exp_q.delete();
        for (int v = SLEW_STEP; v < 100; v += SLEW_STEP) exp_q.push_back(8'(v));
        exp_q.push_back(8'd100);
        mode_dpad = 1'b1;
        cyc(1);
        check("sw_slewing", int'(slewing), 1);
        check("sw_src_hold", int'(thrust_src), 0);
        collect_slew(300);
        compare_seq("slew_up");
        check("sw_src", int'(thrust_src), 1);

        // mode toggle mid-slew at thrust 40
        mode_dpad = 1'b0;
        wait_settled("settle_analog2", 300);
        mode_dpad = 1'b1;
        n = 0;
        while (int'(thrust) != 40 && n < 200) begin
            cyc(1);
            n++;
        end
        check("reach40", int'(thrust), 40);
        mode_dpad = 1'b0;
        exp_q.delete();
        for (int v = 40 - SLEW_STEP; v >= 0; v -= SLEW_STEP) exp_q.push_back(8'(v));
        collect_slew(300);
        compare_seq("slew_back");
        check("toggle_src", int'(thrust_src), 0);

        // coin pulses
        coin_press("coin1", 50);
        coin_press("coin2", 50);
        p0 = pulses;
        coin_btn = 1'b1;
        cyc(2);
        coin_btn = 1'b0;
        cyc(15);
        check("coin_short", pulses - p0, 1);

        // reset during coin pulse and slew
        mode_dpad = 1'b1;
        coin_btn = 1'b1;
        cyc(4);
        check("pre_rst_coin", int'(coin_l), 0);
        check("pre_rst_slew", int'(slewing), 1);
        #2 RESET_L = 1'b0;
        #1;
        check("mid_rst_thrust", int'(thrust), 0);
        check("mid_rst_coin", int'(coin_l), 1);
        check("mid_rst_slew", int'(slewing), 1);
        prev_slew = 1'b0;
        cyc(3);
        coin_btn = 1'b0;
        RESET_L = 1'b1;
        wait_settled("rst_settle", 300);
        check("rst_reconv", int'(thrust), 0);
        check("rst_reconv_src", int'(thrust_src), 1);
        mode_dpad = 1'b0;
        analog_y = 8'h00;
        wait_settled("rst_settle2", 300);
        check("rst_analog", int'(thrust), 127);

        // randomized stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(63) == 0) mode_dpad = ~mode_dpad;
            if ($urandom_range(7) == 0) analog_y = 8'($urandom_range(255));
            if ($urandom_range(15) == 0) begin
                dpad_up   = 1'($urandom_range(1));
                dpad_down = 1'($urandom_range(1));
            end
            if ($urandom_range(39) == 0) coin_btn = ~coin_btn;
            cyc(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
